// File: rtl/flag_unit.sv
// ALU flag consumer: architectural ZF/VF/NF register, sticky illegal-opcode flag,
// and zero-latency branch resolution with an optional EX->ID flag bypass.
module flag_unit #(
    parameter logic [2:0] RESET_FLAGS = 3'b000,
    parameter bit         BYPASS_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic       ex_alu,
    input  logic [3:0] ex_opcode,
    input  logic       Z_set,
    input  logic       V_set,
    input  logic       N_set,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic       ZF,
    output logic       VF,
    output logic       NF,
    output logic       br_taken,
    output logic       opc_err
);

    logic r_zf, r_vf, r_nf, r_opc_err;
    logic w_we, w_live, w_upd_all, w_upd_z;
    logic w_ez, w_ev, w_en, w_cond;

    // ADD/SUB write all three flags; the logic/shift group writes only ZF.
    assign w_upd_all = (ex_opcode == 4'h0) || (ex_opcode == 4'h1);
    assign w_upd_z   = w_upd_all || (ex_opcode == 4'h2) || (ex_opcode == 4'h4) ||
                       (ex_opcode == 4'h5) || (ex_opcode == 4'h6);

    assign w_live = ex_valid & ~flush;
    assign w_we   = w_live & ~stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {r_zf, r_vf, r_nf} <= RESET_FLAGS;
            r_opc_err          <= 1'b0;
        end else if (w_we) begin
            if (w_upd_z)   r_zf <= Z_set;
            if (w_upd_all) begin
                r_vf <= V_set;
                r_nf <= N_set;
            end
            if (ex_alu && (ex_opcode > 4'hB)) r_opc_err <= 1'b1;
        end
    end

    // Bypass ignores stall so a held branch keeps seeing the pending EX result.
    assign w_ez = (BYPASS_EN && w_live && w_upd_z)   ? Z_set : r_zf;
    assign w_ev = (BYPASS_EN && w_live && w_upd_all) ? V_set : r_vf;
    assign w_en = (BYPASS_EN && w_live && w_upd_all) ? N_set : r_nf;

    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b000: w_cond = ~w_ez;
            3'b001: w_cond = w_ez;
            3'b010: w_cond = ~w_ez & ~w_en;
            3'b011: w_cond = w_en;
            3'b100: w_cond = w_ez | (~w_ez & ~w_en);
            3'b101: w_cond = w_en | w_ez;
            3'b110: w_cond = w_ev;
            3'b111: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign br_taken = rst_n & br_valid & w_cond;
    assign ZF       = r_zf;
    assign VF       = r_vf;
    assign NF       = r_nf;
    assign opc_err  = r_opc_err;

endmodule

// File: tb/tb_flag_unit.sv
// Directed scenarios plus random traffic against a behavioural flag model;
// a second instance with the bypass disabled checks the delayed branch view.
module tb_flag_unit;

    logic clk = 1'b0;
    logic rst_n, stall, flush, ex_valid, ex_alu, Z_set, V_set, N_set, br_valid;
    logic [3:0] ex_opcode;
    logic [2:0] br_cond;
    logic zf_a, vf_a, nf_a, bt_a, err_a;
    logic zf_b, vf_b, nf_b, bt_b, err_b;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_z, m_v, m_n, m_err;
    logic obs_a, obs_b;

    always #5 clk = ~clk;

    flag_unit #(.RESET_FLAGS(3'b000), .BYPASS_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_alu(ex_alu), .ex_opcode(ex_opcode), .Z_set(Z_set), .V_set(V_set), .N_set(N_set),
        .br_valid(br_valid), .br_cond(br_cond), .ZF(zf_a), .VF(vf_a), .NF(nf_a),
        .br_taken(bt_a), .opc_err(err_a));

    flag_unit #(.RESET_FLAGS(3'b000), .BYPASS_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_alu(ex_alu), .ex_opcode(ex_opcode), .Z_set(Z_set), .V_set(V_set), .N_set(N_set),
        .br_valid(br_valid), .br_cond(br_cond), .ZF(zf_b), .VF(vf_b), .NF(nf_b),
        .br_taken(bt_b), .opc_err(err_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit writes_all(input logic [3:0] op);
        return op inside {4'h0, 4'h1};
    endfunction

    function automatic bit writes_z(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    endfunction

    function automatic bit cond_true(input logic [2:0] c, input bit z, input bit v, input bit n);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: drive, check outputs against the model mid-cycle, then advance model at the edge.
    task automatic cyc(input bit rst, input bit stl, input bit fl, input bit exv, input bit alu,
                       input logic [3:0] op, input bit z, input bit v, input bit n,
                       input bit brv, input logic [2:0] c);
        bit ez, ev, en, byp, exp_a, exp_b;
        @(negedge clk);
        rst_n = rst; stall = stl; flush = fl; ex_valid = exv; ex_alu = alu; ex_opcode = op;
        Z_set = z; V_set = v; N_set = n; br_valid = brv; br_cond = c;
        #1;
        byp = exv && !fl;
        ez = (byp && writes_z(op))   ? z : m_z;
        ev = (byp && writes_all(op)) ? v : m_v;
        en = (byp && writes_all(op)) ? n : m_n;
        exp_a = rst && brv && cond_true(c, ez, ev, en);
        exp_b = rst && brv && cond_true(c, m_z, m_v, m_n);
        obs_a = bt_a;
        obs_b = bt_b;
        chk("flags_a", {zf_a, vf_a, nf_a}, {m_z, m_v, m_n});
        chk("flags_b", {zf_b, vf_b, nf_b}, {m_z, m_v, m_n});
        chk("br_a", bt_a, exp_a);
        chk("br_b", bt_b, exp_b);
        chk("err", err_a, m_err);
        @(posedge clk);
        if (!rst) begin
            {m_z, m_v, m_n} = 3'b000;
            m_err = 1'b0;
        end else if (exv && !fl && !stl) begin
            if (writes_z(op)) m_z = z;
            if (writes_all(op)) begin m_v = v; m_n = n; end
            if (alu && op > 4'hB) m_err = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; ex_valid = 0; ex_alu = 0; ex_opcode = 0;
        Z_set = 0; V_set = 0; N_set = 0; br_valid = 0; br_cond = 0;
        m_z = 0; m_v = 0; m_n = 0; m_err = 0;
        // settle registers before the model is trusted
        @(posedge clk); #1;

        // 1 reset with an active ADD writer and an unconditional branch
        cyc(0, 0, 0, 1, 1, 4'h0, 1, 1, 1, 1, 3'd7);
        chk("t1_bt0", obs_a, 1'b0);
        cyc(0, 0, 0, 1, 1, 4'h0, 1, 1, 1, 1, 3'd7);
        chk("t1_bt1", obs_a, 1'b0);
        chk("t1_flags", {zf_a, vf_a, nf_a}, 3'b000);

        // 2 ADD then XOR then RED
        cyc(1, 0, 0, 1, 1, 4'h0, 0, 1, 1, 0, 3'd0);
        cyc(1, 0, 0, 1, 1, 4'h2, 1, 0, 0, 0, 3'd0);
        chk("t2_xor", {zf_a, vf_a, nf_a}, 3'b111);
        cyc(1, 0, 0, 1, 1, 4'h3, 0, 0, 0, 0, 3'd0);
        chk("t2_red", {zf_a, vf_a, nf_a}, 3'b111);

        // 3 bypass: SUB Z=1 behind cleared flags, branch EQ
        cyc(1, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 3'd0);
        cyc(1, 0, 0, 1, 1, 4'h1, 1, 0, 0, 1, 3'd1);
        chk("t3_byp", obs_a, 1'b1);
        chk("t3_nobyp", obs_b, 1'b0);
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 3'd1);
        chk("t3_late", obs_b, 1'b1);

        // 4 flush blocks both write and bypass
        cyc(1, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 3'd0);
        cyc(1, 0, 1, 1, 1, 4'h0, 1, 0, 0, 1, 3'd1);
        chk("t4_bt", obs_a, 1'b0);
        chk("t4_zf", zf_a, 1'b0);

        // 5 stall holds NF while bypass still shows it
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 1, 1, 4'h0, 0, 0, 1, 1, 3'd3);
            chk("t5_bt", obs_a, 1'b1);
            chk("t5_nf", nf_a, 1'b0);
        end
        cyc(1, 0, 0, 1, 1, 4'h0, 0, 0, 1, 1, 3'd3);
        chk("t5_nf_after", nf_a, 1'b1);

        // 6 condition sweep, then sticky opcode error
        for (int f = 0; f < 8; f++) begin
            cyc(1, 0, 0, 1, 1, 4'h0, f[2], f[1], f[0], 0, 3'd0);
            for (int c = 0; c < 8; c++)
                cyc(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, c[2:0]);
        end
        cyc(1, 0, 0, 1, 1, 4'hE, 0, 0, 0, 0, 3'd0);
        chk("t6_err", err_a, 1'b1);
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 3'd0);
        cyc(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 3'd0);
        chk("t6_sticky", err_a, 1'b1);
        cyc(0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 3'd0);
        chk("t6_clr", err_a, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
